keymem_req_arbiter: RTL



---
 rtl/keymem_arb_pkg.sv | 14 +
 rtl/keymem_req_arbiter_rr_arbiter.sv | 30 +++
 rtl/keymem_req_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/keymem_arb_pkg.sv
// rtl/keymem_arb_pkg.sv - shared widths and FSM state type for the key request arbiter
package keymem_arb_pkg;

    localparam int KEY_ID_WIDTH = 32;
    localparam int KEY_WIDTH    = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/keymem_req_arbiter_rr_arbiter.sv
// rtl/keymem_req_arbiter_rr_arbiter.sv - combinational round-robin picker starting after last_grant
module rr_arbiter
    import keymem_arb_pkg::*;
#(
    parameter int NUM_PATHS = 4,
    parameter int GRANT_W   = 2
) (
    input  logic [NUM_PATHS-1:0] req,
    input  logic [GRANT_W-1:0]   last_grant,
    output logic [GRANT_W-1:0]   grant,
    output logic                 any_req
);

    logic [GRANT_W-1:0] idx;

    // Walk from the farthest offset down so the nearest requester after last_grant wins.
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int off = NUM_PATHS; off >= 1; off--) begin
            idx = GRANT_W'((int'(last_grant) + off) % NUM_PATHS);
            if (req[idx]) begin
                grant   = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/keymem_req_arbiter.sv
// rtl/keymem_req_arbiter.sv - round-robin key lookup arbiter onto one keymem port; optional KEYMEM_ARB_TIMEOUT_EN
module keymem_req_arbiter
    import keymem_arb_pkg::*;
#(
    parameter int NUM_PATHS      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           key_clk,
    input  logic                           key_aresetn,
    input  logic [NUM_PATHS-1:0]           path_key_req,
    input  logic [NUM_PATHS*KEY_ID_WIDTH-1:0] path_key_id,
    output logic [NUM_PATHS-1:0]           path_key_ack,
    output logic [NUM_PATHS-1:0]           path_key_err,
    output logic [KEY_WIDTH-1:0]           path_key,
    output logic                           km_key_req,
    output logic [KEY_ID_WIDTH-1:0]        km_key_id,
    input  logic                           km_key_ack,
    input  logic [KEY_WIDTH-1:0]           km_key,
    output logic                           busy
);

    localparam int GRANT_W = $clog2(NUM_PATHS);

    if (NUM_PATHS < 2 || NUM_PATHS > 12 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("keymem_req_arbiter: unsupported NUM_PATHS or TIMEOUT_CYCLES");
    end

    arb_state_e              state, state_d;
    logic [GRANT_W-1:0]      grant, grant_d, last_grant, last_grant_d, pick;
    logic                    pick_valid;
    logic [KEY_ID_WIDTH-1:0] ids [NUM_PATHS];
    logic [KEY_ID_WIDTH-1:0] km_key_id_d;
    logic [KEY_WIDTH-1:0]    path_key_d;
    logic [NUM_PATHS-1:0]    ack_d, err_d;
    logic                    km_key_req_d, busy_d, timed_out;

    for (genvar i = 0; i < NUM_PATHS; i++) begin : g_ids
        assign ids[i] = path_key_id[i*KEY_ID_WIDTH +: KEY_ID_WIDTH];
    end

    rr_arbiter #(
        .NUM_PATHS (NUM_PATHS),
        .GRANT_W   (GRANT_W)
    ) u_rr (
        .req        (path_key_req),
        .last_grant (last_grant),
        .grant      (pick),
        .any_req    (pick_valid)
    );

`ifdef KEYMEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] wait_cnt, wait_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt;
        if (state == ISSUE)
            wait_cnt_d = '0;
        else if (state == WAIT)
            wait_cnt_d = wait_cnt + 1'b1;
    end

    always_ff @(posedge key_clk or negedge key_aresetn) begin
        if (!key_aresetn)
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt_d;
    end

    assign timed_out = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_d      = state;
        grant_d      = grant;
        last_grant_d = last_grant;
        km_key_id_d  = km_key_id;
        path_key_d   = path_key;
        km_key_req_d = 1'b0;
        ack_d        = '0;
        err_d        = '0;
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    grant_d      = pick;
                    km_key_id_d  = ids[pick];
                    km_key_req_d = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                // A real ack wins over a timeout that expires in the same cycle.
                if (km_key_ack) begin
                    path_key_d   = km_key;
                    ack_d[grant] = 1'b1;
                    state_d      = RESP;
                end else if (timed_out) begin
                    path_key_d   = '0;
                    ack_d[grant] = 1'b1;
                    err_d[grant] = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                last_grant_d = grant;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge key_clk or negedge key_aresetn) begin
        if (!key_aresetn) begin
            state        <= IDLE;
            grant        <= '0;
            last_grant   <= GRANT_W'(NUM_PATHS - 1);
            km_key_id    <= '0;
            km_key_req   <= 1'b0;
            path_key     <= '0;
            path_key_ack <= '0;
            path_key_err <= '0;
            busy         <= 1'b0;
        end else begin
            state        <= state_d;
            grant        <= grant_d;
            last_grant   <= last_grant_d;
            km_key_id    <= km_key_id_d;
            km_key_req   <= km_key_req_d;
            path_key     <= path_key_d;
            path_key_ack <= ack_d;
            path_key_err <= err_d;
            busy         <= busy_d;
        end
    end

endmodule
